// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 measurement control unit:
// state codes, attempt counter width and the default guard interval.
package hcsr04_pkg;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    ENVIA    = 4'd2,
    ESPERA   = 4'd3,
    ARMAZENA = 4'd4,
    FINAL    = 4'd5,
    GUARDA   = 4'd6,
    FALHA    = 4'd7
  } estado_t;

  localparam int TENT_W = 4;

  // 60 ms at 50 MHz between trigger bursts
  localparam int GUARDA_CLOCKS_PADRAO = 3_000_000;

  // A one-cycle guard still needs a 1-bit counter
  function automatic int guarda_largura(input int clocks);
    return (clocks > 1) ? $clog2(clocks) : 1;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear and enable; fim flags the
// terminal count M-1 so the owner can leave after exactly M enabled cycles.
module contador_m #(
  parameter int M = 100,
  parameter int N = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);

  logic [N-1:0] q_reg, q_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  always_comb begin
    q_next = q_reg;
    if (zera_s) begin
      q_next = '0;
    end else if (conta) begin
      q_next = (q_reg == ULTIMO) ? '0 : q_reg + 1'b1;
    end
  end

  assign fim = (q_reg == ULTIMO);

endmodule

// File: rtl/hcsr04_medidor_uc.sv
// HC-SR04 measurement sequencer: trigger, echo wait with retry on timeout,
// minimum guard between bursts, and completion/failure reporting.
module hcsr04_medidor_uc
  import hcsr04_pkg::*;
#(
  parameter int MAX_TENTATIVAS = 3,
  parameter int GUARDA_CLOCKS  = GUARDA_CLOCKS_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              medir,
  input  logic              modo_continuo,
  input  logic              parar,
  input  logic              fim_medida,
  input  logic              timeout,
  output logic              zera,
  output logic              gera,
  output logic              conta_timeout,
  output logic              registra,
  output logic              pronto,
  output logic              erro,
  output logic [TENT_W-1:0] tentativas,
  output logic [3:0]        db_estado
);

  localparam int                GUARDA_W = guarda_largura(GUARDA_CLOCKS);
  localparam logic [TENT_W-1:0] MAX_T    = TENT_W'(MAX_TENTATIVAS);

  estado_t           estado_reg, estado_next;
  logic [TENT_W-1:0] tent_reg, tent_next;
  logic              erro_reg, erro_next;
  logic              retry_reg, retry_next;
  logic              guarda_fim, guarda_zera, guarda_conta;
  logic [6:1]        estado_oh;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_reg <= INICIAL;
      tent_reg   <= '0;
      erro_reg   <= 1'b0;
      retry_reg  <= 1'b0;
    end else begin
      estado_reg <= estado_next;
      tent_reg   <= tent_next;
      erro_reg   <= erro_next;
      retry_reg  <= retry_next;
    end
  end

  always_comb begin
    estado_next = estado_reg;
    tent_next   = tent_reg;
    erro_next   = erro_reg;
    retry_next  = retry_reg;
    if (parar) begin
      // Abort keeps erro/tentativas visible for the application
      estado_next = INICIAL;
      retry_next  = 1'b0;
    end else begin
      case (estado_reg)
        INICIAL: begin
          if (medir) begin
            estado_next = PREPARA;
            erro_next   = 1'b0;
            tent_next   = '0;
          end
        end
        PREPARA: estado_next = ENVIA;
        ENVIA: begin
          estado_next = ESPERA;
          tent_next   = tent_reg + 1'b1;
        end
        ESPERA: begin
          if (fim_medida) begin
            estado_next = ARMAZENA;
          end else if (timeout) begin
            if (tent_reg < MAX_T) begin
              estado_next = GUARDA;
              retry_next  = 1'b1;
            end else begin
              estado_next = FALHA;
              erro_next   = 1'b1;
            end
          end
        end
        ARMAZENA: estado_next = FINAL;
        FINAL:    estado_next = GUARDA;
        FALHA: begin
          estado_next = GUARDA;
          erro_next   = 1'b1;
        end
        GUARDA: begin
          if (guarda_fim) begin
            if (retry_reg) begin
              estado_next = PREPARA;
              retry_next  = 1'b0;
            end else if (modo_continuo) begin
              estado_next = PREPARA;
              tent_next   = '0;
              erro_next   = 1'b0;
            end else begin
              estado_next = INICIAL;
            end
          end
        end
        default: estado_next = INICIAL;
      endcase
    end
  end

  // One-hot decode of the registered state feeds every Moore output
  for (genvar gi = 1; gi <= 6; gi++) begin : g_decod
    assign estado_oh[gi] = (estado_reg == 4'(gi));
  end

  assign guarda_zera  = ~estado_oh[6] | parar;
  assign guarda_conta = estado_oh[6] & ~parar;

  contador_m #(
    .M(GUARDA_CLOCKS),
    .N(GUARDA_W)
  ) u_guarda (
    .clock (clock),
    .reset (reset),
    .zera_s(guarda_zera),
    .conta (guarda_conta),
    .fim   (guarda_fim)
  );

  assign zera          = estado_oh[1];
  assign gera          = estado_oh[2];
  assign conta_timeout = estado_oh[3];
  assign registra      = estado_oh[4];
  assign pronto        = estado_oh[5];
  assign erro          = erro_reg;
  assign tentativas    = tent_reg;
  assign db_estado     = estado_reg;

endmodule

// File: tb/tb_hcsr04_medidor_uc.sv
// Directed bench for hcsr04_medidor_uc: pulse outputs are scored against
// expected cycle numbers queued when the stimulus is driven.
module tb_hcsr04_medidor_uc;

  localparam int G = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       medir = 1'b0;
  logic       modo_continuo = 1'b0;
  logic       parar = 1'b0;
  logic       fim_medida = 1'b0;
  logic       timeout = 1'b0;
  logic       zera, gera, conta_timeout, registra, pronto, erro;
  logic [3:0] tentativas;
  logic [3:0] db_estado;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int q_zera[$];
  int q_gera[$];
  int q_reg[$];
  int q_pronto[$];

  hcsr04_medidor_uc #(
    .MAX_TENTATIVAS(3),
    .GUARDA_CLOCKS (G)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .medir        (medir),
    .modo_continuo(modo_continuo),
    .parar        (parar),
    .fim_medida   (fim_medida),
    .timeout      (timeout),
    .zera         (zera),
    .gera         (gera),
    .conta_timeout(conta_timeout),
    .registra     (registra),
    .pronto       (pronto),
    .erro         (erro),
    .tentativas   (tentativas),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic score(input int id, input string nm);
    int exp_c;
    exp_c = -1;
    case (id)
      0: if (q_zera.size() > 0) exp_c = q_zera.pop_front();
      1: if (q_gera.size() > 0) exp_c = q_gera.pop_front();
      2: if (q_reg.size() > 0) exp_c = q_reg.pop_front();
      default: if (q_pronto.size() > 0) exp_c = q_pronto.pop_front();
    endcase
    vectors++;
    assert (cyc === exp_c) else begin
      miscompares++;
      $error("FAIL pulse_%s: observed at cycle %0d expected cycle %0d", nm, cyc, exp_c);
    end
  endtask

  // Scoreboard side: every pulse cycle consumes one queued expectation
  always @(negedge clock) begin
    if (zera) score(0, "zera");
    if (gera) score(1, "gera");
    if (registra) score(2, "registra");
    if (pronto) begin
      score(3, "pronto");
      $display("txn pronto cycle=%0d tentativas=%0d", cyc, tentativas);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic req_medida();
    medir = 1'b1;
    q_zera.push_back(cyc + 1);
    q_gera.push_back(cyc + 2);
    tick(1);
    medir = 1'b0;
  endtask

  task automatic fim_pulse(input logic com_timeout);
    fim_medida = 1'b1;
    timeout    = com_timeout;
    q_reg.push_back(cyc + 1);
    q_pronto.push_back(cyc + 2);
    tick(1);
    fim_medida = 1'b0;
    timeout    = 1'b0;
  endtask

  task automatic timeout_pulse(input logic retry);
    timeout = 1'b1;
    if (retry) begin
      q_zera.push_back(cyc + G + 1);
      q_gera.push_back(cyc + G + 2);
    end
    tick(1);
    timeout = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b0;
    tick(2);
    chk("rst_db_estado", db_estado, 0);
    chk("rst_outs", {zera, gera, conta_timeout, registra, pronto, erro}, 0);
    chk("rst_tentativas", tentativas, 0);
    reset = 1'b1;
    tick(2);

    // Single measurement, echo 20 cycles after the trigger
    $display("txn single measurement");
    req_medida();
    chk("s1_prepara", db_estado, 1);
    tick(1);
    chk("s1_envia", db_estado, 2);
    tick(1);
    chk("s1_espera", db_estado, 3);
    chk("s1_conta_timeout", conta_timeout, 1);
    tick(19);
    chk("s1_espera_hold", db_estado, 3);
    fim_pulse(1'b0);
    chk("s1_armazena", db_estado, 4);
    tick(1);
    chk("s1_final", db_estado, 5);
    chk("s1_tentativas", tentativas, 1);
    for (int i = 0; i < G; i++) begin
      tick(1);
      chk("s1_guarda", db_estado, 6);
    end
    tick(1);
    chk("s1_inicial", db_estado, 0);
    chk("s1_erro", erro, 0);
    chk("s1_tent_hold", tentativas, 1);

    // Timeout on attempt 1, echo on attempt 2
    $display("txn retry then success");
    req_medida();
    tick(2);
    timeout_pulse(1'b1);
    chk("s2_guarda", db_estado, 6);
    chk("s2_tent1", tentativas, 1);
    tick(10);
    chk("s2_espera2", db_estado, 3);
    chk("s2_tent2", tentativas, 2);
    fim_pulse(1'b0);
    tick(G + 2);
    chk("s2_inicial", db_estado, 0);
    chk("s2_tentativas", tentativas, 2);
    chk("s2_erro", erro, 0);

    // Three timeouts end in FALHA with sticky erro
    $display("txn failure after three attempts");
    req_medida();
    tick(2);
    timeout_pulse(1'b1);
    tick(10);
    timeout_pulse(1'b1);
    tick(10);
    chk("s3_tent3", tentativas, 3);
    timeout_pulse(1'b0);
    chk("s3_falha", db_estado, 7);
    tick(1);
    chk("s3_guarda", db_estado, 6);
    chk("s3_erro_guarda", erro, 1);
    tick(G);
    chk("s3_inicial", db_estado, 0);
    chk("s3_erro_inicial", erro, 1);
    tick(3);
    chk("s3_erro_hold", erro, 1);

    // Next request clears erro; simultaneous echo and timeout: echo wins
    $display("txn recovery with fim_medida and timeout together");
    req_medida();
    chk("s5_erro_clr", erro, 0);
    chk("s5_tent_clr", tentativas, 0);
    tick(2);
    fim_pulse(1'b1);
    chk("s5_armazena", db_estado, 4);
    tick(G + 2);
    chk("s5_inicial", db_estado, 0);
    chk("s5_tentativas", tentativas, 1);

    // Continuous mode, four periods, drop the mode during the last one
    $display("txn continuous mode");
    modo_continuo = 1'b1;
    req_medida();
    tick(2);
    for (int p = 0; p < 4; p++) begin
      tick(2);
      chk("s4_espera", db_estado, 3);
      chk("s4_tent", tentativas, 1);
      if (p == 3) modo_continuo = 1'b0;
      if (p < 3) begin
        q_zera.push_back(cyc + G + 3);
        q_gera.push_back(cyc + G + 4);
      end
      fim_pulse(1'b0);
      if (p < 3) tick(G + 4);
    end
    tick(G + 2);
    chk("s4_inicial", db_estado, 0);

    // Abort while waiting for the echo
    $display("txn parar in ESPERA");
    req_medida();
    tick(2);
    chk("s6_conta_on", conta_timeout, 1);
    parar = 1'b1;
    tick(1);
    parar = 1'b0;
    chk("s6_inicial", db_estado, 0);
    chk("s6_conta_off", conta_timeout, 0);
    chk("s6_tent_hold", tentativas, 1);
    tick(2);
    chk("s6_stay", db_estado, 0);

    // Asynchronous reset while the trigger is being generated
    $display("txn reset in ENVIA");
    req_medida();
    tick(1);
    chk("s7_gera", gera, 1);
    #1 reset = 1'b0;
    #1;
    chk("s7_outs", {zera, gera, conta_timeout, registra, pronto, erro}, 0);
    chk("s7_db", db_estado, 0);
    chk("s7_tent", tentativas, 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    req_medida();
    tick(2);
    chk("s7_espera", db_estado, 3);
    fim_pulse(1'b0);
    tick(G + 2);
    chk("s7_inicial", db_estado, 0);
    chk("s7_tentativas", tentativas, 1);

    tick(2);
    chk("end_q_zera", q_zera.size(), 0);
    chk("end_q_gera", q_gera.size(), 0);
    chk("end_q_registra", q_reg.size(), 0);
    chk("end_q_pronto", q_pronto.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
